// File: rtl/nested_isqrt_fsm_pkg.sv
// nested_isqrt_pkg: state encoding and sizing helper for nested_isqrt_fsm.
// Rev 1.0
`default_nettype none

package nested_isqrt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One extra bit so that N-1 always fits, including the N = 1 case.
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nested_isqrt_fsm.sv
// nested_isqrt_fsm: evaluates isqrt(arg[0] + isqrt(arg[1] + ... + isqrt(arg[N-1])))
// through one shared external isqrt unit. Rev 1.0
`default_nettype none

module nested_isqrt_fsm
  import nested_isqrt_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arg_vld,
  output logic           arg_rdy,
  input  logic [N*W-1:0] args,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [W-1:0]   res,
  output logic           isqrt_x_vld,
  output logic [W-1:0]   isqrt_x,
  input  logic           isqrt_y_vld,
  input  logic [W/2-1:0] isqrt_y
);

  localparam int IW = idx_width(N);
  localparam int H  = W / 2;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  arg_q [N];
  logic [H-1:0]  res_q;

  logic [IW-1:0] prev_idx;
  logic [W-1:0]  prev_arg;
  logic [W-1:0]  y_ext;

  assign prev_idx = idx_q - 1'b1;
  assign y_ext    = {{(W-H){1'b0}}, isqrt_y};

  always_comb begin
    prev_arg = '0;
    for (int i = 0; i < N; i++) begin
      if (prev_idx == IW'(i)) prev_arg = arg_q[i];
    end
  end

  // Requests are issued combinationally so each chained step costs no extra cycle.
  always_comb begin
    isqrt_x_vld = 1'b0;
    isqrt_x     = '0;
    case (state_q)
      S_IDLE: begin
        if (arg_vld) begin
          isqrt_x_vld = 1'b1;
          isqrt_x     = args[(N-1)*W +: W];
        end
      end
      S_WAIT: begin
        if (isqrt_y_vld && (idx_q != '0)) begin
          isqrt_x_vld = 1'b1;
          isqrt_x     = prev_arg + y_ext;
        end
      end
      default: ;
    endcase
  end

  assign arg_rdy = (state_q == S_IDLE);
  assign res_vld = (state_q == S_DONE);
  assign res     = res_vld ? {{(W-H){1'b0}}, res_q} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      for (int i = 0; i < N; i++) arg_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arg_vld) begin
            for (int i = 0; i < N; i++) arg_q[i] <= args[i*W +: W];
            idx_q   <= IW'(N - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (isqrt_y_vld) begin
            if (idx_q != '0) begin
              idx_q <= prev_idx;
            end else begin
              res_q   <= isqrt_y;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (res_rdy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
